// File: rtl/ysyx_22041752_meu_q.sv
// Queued memory-execute stage: holds up to DEPTH in-flight instructions in program order,
// matches in-order memory responses to the oldest waiting op and retires in order.
module ysyx_22041752_meu_q #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PC_WD      = 32,
  parameter int unsigned RF_ADDR_WD = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           es_to_ms_valid,
  output logic                           ms_allowin,
  input  logic [PC_WD-1:0]               es_pc,
  input  logic [RF_ADDR_WD-1:0]          es_rd,
  input  logic                           es_rf_we,
  input  logic                           es_mem_re,
  input  logic                           es_mem_we,
  input  logic [1:0]                     es_mem_bytes,
  input  logic                           es_sext,
  input  logic [$clog2(XLEN/8)-1:0]      es_addr_offset,
  input  logic [XLEN-1:0]                es_alu_result,
  input  logic [XLEN-1:0]                data_rdata,
  input  logic                           rdata_valid,
  input  logic                           ws_allowin,
  output logic                           ms_to_ws_valid,
  output logic                           ms_rf_we,
  output logic [RF_ADDR_WD-1:0]          ms_rd,
  output logic [XLEN-1:0]                ms_final_result,
  output logic [PC_WD-1:0]               ms_pc,
  output logic [DEPTH-1:0]               fwd_valid,
  output logic [DEPTH-1:0]               fwd_busy,
  output logic [DEPTH*RF_ADDR_WD-1:0]    fwd_rd,
  output logic [DEPTH*XLEN-1:0]          fwd_data,
  output logic                           ms_empty,
  output logic                           rsp_err
);

  localparam int unsigned OFF_WD = $clog2(XLEN / 8);
  localparam int unsigned PTR_WD = $clog2(DEPTH);
  localparam int unsigned CNT_WD = PTR_WD + 1;

  typedef logic [PTR_WD-1:0] ptr_t;

  // Extension done by shifting the field to the top and back, so one path covers every size.
  function automatic logic [XLEN-1:0] load_fmt(input logic [XLEN-1:0]   data,
                                               input logic [OFF_WD-1:0] off,
                                               input logic [1:0]        size,
                                               input logic              sext);
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] t;
    logic [7:0]      sh;
    shifted = data >> {off, 3'b000};
    case (size)
      2'b00:   sh = 8'(XLEN - 8);
      2'b01:   sh = 8'(XLEN - 16);
      2'b10:   sh = 8'(XLEN - 32);
      default: sh = 8'd0;
    endcase
    t = shifted << sh;
    load_fmt = sext ? $unsigned($signed(t) >>> sh) : (t >> sh);
  endfunction

  ptr_t              head_q, tail_q;
  logic [CNT_WD-1:0] count_q;
  logic [DEPTH-1:0]  done_q;
  logic              rsp_err_q;

  // Payload storage, intentionally not reset.
  logic [PC_WD-1:0]      pc_q    [DEPTH];
  logic [RF_ADDR_WD-1:0] rd_q    [DEPTH];
  logic [1:0]            size_q  [DEPTH];
  logic [OFF_WD-1:0]     off_q   [DEPTH];
  logic [XLEN-1:0]       res_q   [DEPTH];
  logic [DEPTH-1:0]      we_q, mem_q, re_q, sext_q;

  ptr_t             slot_idx [DEPTH];
  logic [DEPTH-1:0] slot_valid, slot_wait;
  logic             rsp_found, rsp_hit, head_bypass, capture, push, pop;
  ptr_t             rsp_idx;
  logic [XLEN-1:0]  rsp_data, rsp_result;

  always_comb begin
    slot_valid = '0;
    slot_wait  = '0;
    rsp_found  = 1'b0;
    rsp_idx    = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      slot_idx[i]   = head_q + ptr_t'(i);
      slot_valid[i] = CNT_WD'(i) < count_q;
      slot_wait[i]  = slot_valid[i] && mem_q[slot_idx[i]] && !done_q[slot_idx[i]];
    end
    // Scan youngest to oldest so the oldest waiting entry wins.
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (slot_wait[i]) begin
        rsp_found = 1'b1;
        rsp_idx   = slot_idx[i];
      end
    end
  end

  assign rsp_hit     = rdata_valid && rsp_found;
  assign rsp_data    = load_fmt(data_rdata, off_q[rsp_idx], size_q[rsp_idx], sext_q[rsp_idx]);
  assign rsp_result  = re_q[rsp_idx] ? rsp_data : res_q[rsp_idx];
  assign head_bypass = rsp_hit && slot_wait[0];

  assign ms_to_ws_valid  = slot_valid[0] && (done_q[head_q] || head_bypass);
  assign ms_rf_we        = we_q[head_q];
  assign ms_rd           = rd_q[head_q];
  assign ms_pc           = pc_q[head_q];
  assign ms_final_result = head_bypass ? rsp_result : res_q[head_q];
  assign ms_empty        = count_q == '0;
  assign rsp_err         = rsp_err_q;

  assign pop        = ms_to_ws_valid && ws_allowin;
  assign ms_allowin = (count_q != CNT_WD'(DEPTH)) || pop;
  assign push       = es_to_ms_valid && ms_allowin;
  assign capture    = rsp_hit && !(head_bypass && pop);

  always_comb begin
    fwd_valid = '0;
    fwd_busy  = '0;
    fwd_rd    = '0;
    fwd_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_valid[i] = slot_valid[i] && we_q[slot_idx[i]];
      fwd_busy[i]  = slot_wait[i] && re_q[slot_idx[i]] && !(i == 0 && head_bypass);
      fwd_rd[i*RF_ADDR_WD +: RF_ADDR_WD] = rd_q[slot_idx[i]];
      fwd_data[i*XLEN +: XLEN] = (i == 0 && head_bypass) ? rsp_result : res_q[slot_idx[i]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      done_q    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (capture) done_q[rsp_idx] <= 1'b1;
      if (pop) begin
        done_q[head_q] <= 1'b0;
        head_q         <= head_q + 1'b1;
      end
      if (push) begin
        done_q[tail_q] <= !(es_mem_re || es_mem_we);
        tail_q         <= tail_q + 1'b1;
      end
      count_q <= count_q + CNT_WD'(push) - CNT_WD'(pop);
      if (rdata_valid && !rsp_found) rsp_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture && re_q[rsp_idx]) res_q[rsp_idx] <= rsp_data;
    if (push) begin
      pc_q[tail_q]   <= es_pc;
      rd_q[tail_q]   <= es_rd;
      we_q[tail_q]   <= es_rf_we;
      mem_q[tail_q]  <= es_mem_re || es_mem_we;
      re_q[tail_q]   <= es_mem_re;
      size_q[tail_q] <= es_mem_bytes;
      sext_q[tail_q] <= es_sext;
      off_q[tail_q]  <= es_addr_offset;
      res_q[tail_q]  <= es_alu_result;
    end
  end

endmodule
